// File: rtl/conv3x3_engine_pkg.sv
// Shared definitions for the 3x3 neighbourhood filter engine.
//   - MODE_* : kernel select codes carried on the mode bus
//   - state_t: sequencing states of the engine FSM
//   - clamp_pix: saturates a signed intermediate into the pixel range
package conv_pkg;

  localparam logic [1:0] MODE_BYPASS  = 2'd0;
  localparam logic [1:0] MODE_BOX     = 2'd1;
  localparam logic [1:0] MODE_SHARPEN = 2'd2;
  localparam logic [1:0] MODE_EDGE    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Cycles needed after the last injected slot for compute and write
  // registers to empty.
  localparam int DRAIN_CYCLES = 3;

  function automatic int clamp_pix(input int value, input int pix_w);
    int max_v;
    max_v = (1 << pix_w) - 1;
    if (value < 0) begin
      return 0;
    end else if (value > max_v) begin
      return max_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Control handshake plus source-read / destination-write RAM ports of the
// filter engine.
//   start/mode      : request and kernel select (driven by the controller)
//   busy/done       : run status back to the controller
//   src_rd_en/addr  : source RAM read request, src_data returns one cycle later
//   dst_we/addr/data: destination RAM write port
// master = controller + RAM side, slave = engine.
interface conv3x3_engine_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [PIX_W-1:0]  src_data;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_data;

  modport master (
    output start, mode, src_data,
    input  busy, done, src_rd_en, src_addr, dst_we, dst_addr, dst_data
  );

  modport slave (
    input  start, mode, src_data,
    output busy, done, src_rd_en, src_addr, dst_we, dst_addr, dst_data
  );
endinterface

// File: rtl/conv3x3_window.sv
// 3x3 sliding window over a raster-order pixel stream.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   clr_i       : synchronous clear of position state at the start of a run
//   adv_i       : a slot is being issued this cycle (its pixel arrives next cycle)
//   flush_i     : the issued slot is a flush slot; a zero is injected instead
//   pix_i       : arriving pixel (valid the cycle after adv_i)
//   win_o       : 9 pixels, index row*3+col, row 0 = top, col 2 = newest
//   win_valid_o : window is centred on a real output pixel this cycle
//   is_border_o : that centre pixel lies on the image border
// The newest window column is combinational from the line-buffer reads and the
// arriving pixel, so the window is usable in the arrival cycle itself.
module conv3x3_window #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   adv_i,
  input  logic                   flush_i,
  input  logic [PIX_W-1:0]       pix_i,
  output logic [8:0][PIX_W-1:0]  win_o,
  output logic                   win_valid_o,
  output logic                   is_border_o
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int LEAD_W = $clog2(IMG_W + 2);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [LEAD_W-1:0] LEAD_FULL = LEAD_W'(IMG_W + 1);

  logic [PIX_W-1:0] lb1_mem [IMG_W];   // previous row
  logic [PIX_W-1:0] lb2_mem [IMG_W];   // row before that
  logic [PIX_W-1:0] lb1_rd_q, lb2_rd_q;

  logic [COL_W-1:0]         issue_col_q, arr_col_q;
  logic                     valid_q, zero_q;
  logic [2:0][PIX_W-1:0]    col0_q, col1_q, col_new;
  logic [LEAD_W-1:0]        lead_q;
  logic [ROW_W-1:0]         crow_q;
  logic [COL_W-1:0]         ccol_q;
  logic [PIX_W-1:0]         in_pix;

  assign in_pix     = zero_q ? '0 : pix_i;
  assign col_new[0] = lb2_rd_q;
  assign col_new[1] = lb1_rd_q;
  assign col_new[2] = in_pix;

  // Line buffers: read is launched in the issue cycle so the registered read
  // data lines up with the arriving pixel; the write of the arriving pixel
  // targets the previous column, never the one being read.
  always_ff @(posedge clk) begin
    if (adv_i) begin
      lb1_rd_q <= lb1_mem[issue_col_q];
      lb2_rd_q <= lb2_mem[issue_col_q];
    end
    if (valid_q) begin
      lb1_mem[arr_col_q] <= in_pix;
      lb2_mem[arr_col_q] <= lb1_rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_col_q <= '0;
      arr_col_q   <= '0;
      valid_q     <= 1'b0;
      zero_q      <= 1'b0;
      lead_q      <= '0;
      crow_q      <= '0;
      ccol_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
    end else if (clr_i) begin
      issue_col_q <= '0;
      arr_col_q   <= '0;
      valid_q     <= 1'b0;
      zero_q      <= 1'b0;
      lead_q      <= '0;
      crow_q      <= '0;
      ccol_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
    end else begin
      valid_q   <= adv_i;
      zero_q    <= flush_i;
      arr_col_q <= issue_col_q;
      if (adv_i) begin
        issue_col_q <= (issue_col_q == COL_LAST) ? '0 : issue_col_q + COL_W'(1);
      end
      if (valid_q) begin
        col0_q <= col1_q;
        col1_q <= col_new;
        // The first IMG_W+1 arrivals only fill the window; afterwards every
        // arrival centres the next output pixel.
        if (lead_q != LEAD_FULL) begin
          lead_q <= lead_q + LEAD_W'(1);
        end else if (ccol_q == COL_LAST) begin
          ccol_q <= '0;
          crow_q <= (crow_q == ROW_LAST) ? '0 : crow_q + ROW_W'(1);
        end else begin
          ccol_q <= ccol_q + COL_W'(1);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign win_o[gi*3 + 0] = col0_q[gi];
      assign win_o[gi*3 + 1] = col1_q[gi];
      assign win_o[gi*3 + 2] = col_new[gi];
    end
  endgenerate

  assign win_valid_o = valid_q && (lead_q == LEAD_FULL);
  assign is_border_o = (crow_q == '0) || (crow_q == ROW_LAST) ||
                       (ccol_q == '0) || (ccol_q == COL_LAST);

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 neighbourhood filter engine: streams a source image out of RAM in
// raster order, filters it with a selectable kernel and writes the result
// to a destination RAM.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : handshake and RAM ports (slave side of conv3x3_engine_if)
// Pipeline: window (combinational on the arriving pixel) -> compute register
// -> write register, giving a write 3 cycles after the centring slot issues.
module conv3x3_engine #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_engine_if.slave bus
);
  import conv_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = PIX_W + 8;   // signed intermediate width
  localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAST_FLUSH = ADDR_W'(IMG_W);

  state_t            state_q;
  logic [ADDR_W-1:0] slot_q;
  logic [1:0]        drain_q;
  logic [1:0]        mode_q;
  logic              busy_q, done_q, rd_en_q;
  logic [ADDR_W-1:0] src_addr_q;

  logic adv, flush, clr;
  logic [8:0][PIX_W-1:0] win;
  logic win_valid, is_border;

  assign adv   = (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign flush = (state_q == ST_FLUSH);
  assign clr   = (state_q == ST_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      drain_q    <= '0;
      mode_q     <= MODE_BYPASS;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      src_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q     <= bus.mode;
            slot_q     <= '0;
            src_addr_q <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          if (slot_q == LAST_SLOT) begin
            slot_q     <= '0;
            rd_en_q    <= 1'b0;
            src_addr_q <= '0;
            state_q    <= ST_FLUSH;
          end else begin
            slot_q     <= slot_q + ADDR_W'(1);
            src_addr_q <= slot_q + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          if (slot_q == LAST_FLUSH) begin
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            slot_q <= slot_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  conv3x3_window #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .adv_i       (adv),
    .flush_i     (flush),
    .pix_i       (bus.src_data),
    .win_o       (win),
    .win_valid_o (win_valid),
    .is_border_o (is_border)
  );

  // Kernel arithmetic on zero-extended signed copies of the window.
  logic signed [CW-1:0] px_s [9];
  logic signed [CW-1:0] sum9_s, box_v, sharp_v, edge_d, edge_v, raw_v;
  logic [PIX_W-1:0]     pix_next;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_px
      assign px_s[gi] = $signed(CW'(win[gi]));
    end
  endgenerate

  always_comb begin
    sum9_s = '0;
    for (int i = 0; i < 9; i++) begin
      sum9_s = sum9_s + px_s[i];
    end
    box_v   = ((sum9_s <<< 3) - sum9_s) >>> 6;           // sum*7 >> 6
    sharp_v = (px_s[4] <<< 2) + px_s[4] - px_s[1] - px_s[7] - px_s[3] - px_s[5];
    edge_d  = (px_s[4] <<< 3) - (sum9_s - px_s[4]);
    edge_v  = edge_d[CW-1] ? -edge_d : edge_d;
    raw_v   = px_s[4];
    case (mode_q)
      MODE_BYPASS:  raw_v = px_s[4];
      MODE_BOX:     raw_v = box_v;
      MODE_SHARPEN: raw_v = sharp_v;
      default:      raw_v = edge_v;
    endcase
    pix_next = PIX_W'(clamp_pix(int'(raw_v), PIX_W));
    if (is_border) begin
      pix_next = win[4];
    end
  end

  logic              res_v_q, we_q;
  logic [PIX_W-1:0]  res_q, wr_data_q;
  logic [ADDR_W-1:0] res_addr_q, wr_addr_q, out_k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_v_q    <= 1'b0;
      res_q      <= '0;
      res_addr_q <= '0;
      out_k_q    <= '0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (clr) begin
        out_k_q <= '0;
      end
      res_v_q <= win_valid;
      if (win_valid) begin
        res_q      <= pix_next;
        res_addr_q <= out_k_q;
        out_k_q    <= out_k_q + ADDR_W'(1);
      end
      we_q <= res_v_q;
      if (res_v_q) begin
        wr_addr_q <= res_addr_q;
        wr_data_q <= res_q;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.src_rd_en = rd_en_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.dst_we    = we_q;
  assign bus.dst_addr  = wr_addr_q;
  assign bus.dst_data  = wr_data_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a non-square 7x5 image.
// A source RAM model answers reads; every write, done pulse and busy sample
// is logged and compared with a 2-D reference filter and the cycle formula.
module tb_conv3x3_engine;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 7;
  localparam int IMG_H  = 5;
  localparam int ADDR_W = 6;
  localparam int NPIX   = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv3x3_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  conv3x3_engine #(
    .PIX_W (PIX_W), .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int src_mem [NPIX];
  int dst_img [NPIX];

  always @(posedge clk) begin
    if (bus.src_rd_en) bus.src_data <= PIX_W'(src_mem[bus.src_addr]);
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int start_edge = 0;
  bit mon_en = 1'b0;
  int mon_rel;
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], done_cyc_q[$];
  int busy_at1, busy_at_done;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_rel = edge_cnt - start_edge;
      if (bus.dst_we) begin
        wr_addr_q.push_back(int'(bus.dst_addr));
        wr_data_q.push_back(int'(bus.dst_data));
        wr_cyc_q.push_back(mon_rel);
      end
      if (bus.done) begin
        done_cyc_q.push_back(mon_rel);
        busy_at_done = int'(bus.busy);
      end
      if (mon_rel == 1) busy_at1 = int'(bus.busy);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    return src_mem[r*IMG_W + c];
  endfunction

  // Reference filter straight from the kernel definitions.
  function automatic int ref_pix(input int mode, input int r, input int c);
    int ctr, sum9, v;
    ctr = px(r, c);
    if (r == 0 || r == IMG_H-1 || c == 0 || c == IMG_W-1) return ctr;
    sum9 = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        sum9 += px(r+dr, c+dc);
    case (mode)
      0: v = ctr;
      1: v = (sum9 * 7) / 64;
      2: v = 5*ctr - px(r-1, c) - px(r+1, c) - px(r, c-1) - px(r, c+1);
      default: begin
        v = 8*ctr - (sum9 - ctr);
        if (v < 0) v = -v;
      end
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic check_quiet_outputs(input string tag);
    check_val({tag, ":busy"},      int'(bus.busy),      0);
    check_val({tag, ":done"},      int'(bus.done),      0);
    check_val({tag, ":src_rd_en"}, int'(bus.src_rd_en), 0);
    check_val({tag, ":src_addr"},  int'(bus.src_addr),  0);
    check_val({tag, ":dst_we"},    int'(bus.dst_we),    0);
    check_val({tag, ":dst_addr"},  int'(bus.dst_addr),  0);
    check_val({tag, ":dst_data"},  int'(bus.dst_data),  0);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
    busy_at1 = -1; busy_at_done = -1;
    for (int i = 0; i < NPIX; i++) dst_img[i] = -1;
  endtask

  task automatic run_image(input int mode, input bit disturb, input string name);
    int waited;
    clear_logs();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'(mode);
    start_edge = edge_cnt; mon_en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (disturb) bus.mode = 2'(mode ^ 3);
    waited = 0;
    while (done_cyc_q.size() == 0 && waited < NPIX + IMG_W + 40) begin
      @(negedge clk);
      waited++;
      if (disturb && waited < NPIX && (waited % 9) == 3) begin
        bus.start = 1'b1; bus.mode = 2'($urandom_range(0, 3));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check_val({name, ":done_count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0)
      check_val({name, ":done_cycle"}, done_cyc_q[0], NPIX + IMG_W + 5);
    check_val({name, ":busy_cycle1"}, busy_at1, 1);
    check_val({name, ":busy_at_done"}, busy_at_done, 0);
    check_val({name, ":n_writes"}, wr_addr_q.size(), NPIX);
    for (int i = 0; i < wr_addr_q.size() && i < NPIX; i++) begin
      check_val($sformatf("%s:addr[%0d]", name, i), wr_addr_q[i], i);
      check_val($sformatf("%s:cycle[%0d]", name, i), wr_cyc_q[i], i + IMG_W + 5);
      check_val($sformatf("%s:data[%0d]", name, i), wr_data_q[i],
                ref_pix(mode, i / IMG_W, i % IMG_W));
      if (wr_addr_q[i] >= 0 && wr_addr_q[i] < NPIX) dst_img[wr_addr_q[i]] = wr_data_q[i];
    end
    $display("run %s mode=%0d disturb=%0d writes=%0d dones=%0d", name, mode, disturb,
             wr_addr_q.size(), done_cyc_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet_outputs("reset");
    rst = 1'b1;

    // Bypass: ramp pattern copied unchanged.
    for (int i = 0; i < NPIX; i++) src_mem[i] = (i * 7) % 256;
    run_image(0, 1'b0, "bypass");
    check_val("bypass:last", dst_img[NPIX-1], ((NPIX-1) * 7) % 256);

    // Box on a flat field.
    for (int i = 0; i < NPIX; i++) src_mem[i] = 100;
    run_image(1, 1'b0, "box_flat");
    check_val("box_flat:interior", dst_img[2*IMG_W + 3], 98);
    check_val("box_flat:border", dst_img[0], 100);

    // Sharpen on a single bright pixel.
    for (int i = 0; i < NPIX; i++) src_mem[i] = 0;
    src_mem[2*IMG_W + 2] = 200;
    run_image(2, 1'b0, "sharp_dot");
    check_val("sharp_dot:centre", dst_img[2*IMG_W + 2], 255);
    check_val("sharp_dot:north", dst_img[1*IMG_W + 2], 0);
    check_val("sharp_dot:east", dst_img[2*IMG_W + 3], 0);

    // Edge on a vertical step between columns 2 and 3.
    for (int i = 0; i < NPIX; i++) src_mem[i] = ((i % IMG_W) >= 3) ? 40 : 0;
    run_image(3, 1'b0, "edge_step");
    check_val("edge_step:col2", dst_img[2*IMG_W + 2], 120);
    check_val("edge_step:col3", dst_img[2*IMG_W + 3], 120);
    check_val("edge_step:col4", dst_img[2*IMG_W + 4], 0);
    check_val("edge_step:border", dst_img[0*IMG_W + 3], 40);

    // Random images in every mode.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < NPIX; i++) src_mem[i] = $urandom_range(0, 255);
      run_image(m, 1'b0, $sformatf("rand_m%0d", m));
    end

    // start and mode disturbed during the run.
    for (int i = 0; i < NPIX; i++) src_mem[i] = $urandom_range(0, 255);
    run_image(2, 1'b1, "disturbed");

    // Asynchronous reset in the middle of READ.
    for (int i = 0; i < NPIX; i++) src_mem[i] = $urandom_range(0, 255);
    clear_logs();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd1;
    start_edge = edge_cnt; mon_en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check_val("pre_rst:busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1 check_quiet_outputs("mid_rst");
    clear_logs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (NPIX + 20) @(negedge clk);
    mon_en = 1'b0;
    check_val("post_rst:done_count", done_cyc_q.size(), 0);
    check_val("post_rst:n_writes", wr_addr_q.size(), 0);
    run_image(1, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
